io_controller: RTL and testbench
================================

Name: io_controller

Overview:
- Responder for the control unit's I/O strobe interface.
- Services io_read/io_write/io_push transfers on the shared 16-bit d_bus, and forwards addresses 3..15 to external peripherals.
- Collects edge-triggered device interrupt requests and raises io_interrupt.
- Stores and returns the interrupted PC, and supplies the vector-table address used by the control unit's interrupt entry sequence.

Parameters:
- NUM_IRQ, 8, number of interrupt request inputs (1..16); bit 0 is highest priority.
- VECTOR_BASE, 16'hFF00, memory address of the vector-table entry for IRQ 0; IRQ n uses VECTOR_BASE+n.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- io_addr  in  4  register/device address; valid whenever io_addr_read=1.
- io_addr_read  in  1  io_addr qualifier.
- io_read  in  1  read request: capture data at io_addr.
- io_push  in  1  drive the captured read data onto d_bus this cycle.
- io_write  in  1  write d_bus into io_addr.
- io_store_retaddr  in  1  d_bus carries the PC: latch it and acknowledge the interrupt.
- io_push_retaddr  in  1  drive the saved return address onto d_bus; end of service.
- io_push_ints  in  1  drive {pending & enable} (zero-extended) onto d_bus.
- io_push_int_addr  in  1  drive the vector address onto a_bus.
- io_interrupt  out  1  interrupt request to the control unit.
- irq  in  NUM_IRQ  device request lines, rising-edge sensitive, synchronous to clk.
- a_bus  out  16  memory address bus contribution; 16'bz unless io_push_int_addr=1.
- d_bus  inout  16  shared data bus.
- dev_rd  out  1  combinational: io_read & io_addr_read & io_addr>=3.
- dev_wr  out  1  combinational: io_write & io_addr_read & io_addr>=3.
- dev_addr  out  4  combinational copy of io_addr.
- dev_wdata  out  16  combinational copy of d_bus.
- dev_rdata  in  16  peripheral read data; valid in the same cycle as dev_rd.

Behaviour:
- Reset (async, rst_n=0):
  - pending=0, enable=0, in_service=0, retaddr=0, last_id=0, rd_hold=0, irq_q=0.
  - io_interrupt=0; a_bus and d_bus high-Z; dev_rd=dev_wr=0.
- Register map:
  - 0 = PENDING: read; write-1-to-clear.
  - 1 = ENABLE: read/write, low NUM_IRQ bits; upper bits read 0.
  - 2 = LAST_ID: read-only, id of the last acknowledged IRQ.
  - 3..15 = external, via the dev_* port.
- Read transfer, two cycles:
  - Cycle N: io_read & io_addr_read → rd_hold <= register value, or dev_rdata for address >=3, at the posedge ending N.
  - Cycle N+1: io_push → d_bus = rd_hold combinationally for the whole cycle.
  - Back-to-back reads are allowed; rd_hold is overwritten only by io_read.
- Write transfer, one cycle: io_write & io_addr_read → register updated at the posedge.
  - Writes to address 2 are ignored.
- IRQ detection:
  - irq_q <= irq; rise = irq & ~irq_q; pending |= rise every cycle.
  - A rising edge in the same cycle as a W1C or an acknowledge clear of that bit wins: the bit stays set.
- io_interrupt = |(pending & enable) & ~in_service; registered output (one-cycle latency from pending/enable/in_service).
- Priority: sel = lowest index set in pending & enable; computed combinationally.
- Interrupt entry (control unit asserts io_store_retaddr and io_push_int_addr in the same cycle):
  - a_bus = VECTOR_BASE + sel, combinational, while io_push_int_addr=1.
  - At the posedge: retaddr <= d_bus; pending[sel] cleared; last_id <= sel; in_service <= 1.
  - If pending & enable == 0 at that edge (spurious): sel=0, no pending bit is cleared, in_service is still set.
- Return:
  - io_push_retaddr → d_bus = retaddr for that cycle.
  - in_service <= 0 at the posedge ending that cycle; io_interrupt may reassert one cycle later.
- Nesting is not supported. A second io_store_retaddr while in_service=1 overwrites retaddr (documented hazard, not guarded).
- d_bus drive priority when several push strobes coincide: io_push_retaddr > io_push > io_push_ints. With none asserted, d_bus=16'bz.
- io_write takes no action on d_bus beyond sampling it.
- Reset mid-transfer: any hold/pending state is lost and the drivers release the bus immediately (asynchronous).

Test Plan:
- ENABLE=8'h05 write, then io_read addr 1 followed by io_push → d_bus=16'h0005 during the push cycle, Z before and after.
- irq[2] 0→1 with ENABLE=8'h04 → PENDING bit 2 set next edge; io_interrupt=1 one edge later. Entry cycle with d_bus=16'h1234 → a_bus=16'hFF02, LAST_ID=2, PENDING=0, io_interrupt drops.
- irq[1] and irq[3] rise together, ENABLE=8'hFF → first ack vectors 16'hFF01. After io_push_retaddr (d_bus=16'h1234), io_interrupt reasserts and the second ack vectors 16'hFF03.
- Held level on irq[0] → only one pending event; a new 0→1 transition in the ack cycle leaves PENDING[0]=1.
- io_write addr 7 with d_bus=16'hBEEF → dev_wr=1, dev_addr=7, dev_wdata=16'hBEEF. io_read addr 9 with dev_rdata=16'h00A5, then io_push → d_bus=16'h00A5.
- rst_n pulsed low during the io_push cycle → d_bus goes Z immediately, io_interrupt=0, ENABLE and PENDING read 0 after release.

Source files
------------

// File: rtl/io_controller_if.sv
// I/O strobe interface between the control unit (master) and the I/O controller (slave).
// The shared data/address buses stay as plain tristate ports on the controller.
interface io_controller_if;
    logic [3:0] io_addr;
    logic       io_addr_read;
    logic       io_read;
    logic       io_push;
    logic       io_write;
    logic       io_store_retaddr;
    logic       io_push_retaddr;
    logic       io_push_ints;
    logic       io_push_int_addr;
    logic       io_interrupt;

    modport master (
        output io_addr,
        output io_addr_read,
        output io_read,
        output io_push,
        output io_write,
        output io_store_retaddr,
        output io_push_retaddr,
        output io_push_ints,
        output io_push_int_addr,
        input  io_interrupt
    );

    modport slave (
        input  io_addr,
        input  io_addr_read,
        input  io_read,
        input  io_push,
        input  io_write,
        input  io_store_retaddr,
        input  io_push_retaddr,
        input  io_push_ints,
        input  io_push_int_addr,
        output io_interrupt
    );
endinterface

// File: rtl/io_controller.sv
// I/O responder: register file, external peripheral forwarding, edge-triggered interrupt
// collection with fixed priority, and return-address/vector support for interrupt entry.
module io_controller #(
    parameter int unsigned NUM_IRQ     = 8,
    parameter logic [15:0] VECTOR_BASE = 16'hFF00
) (
    input  logic               clk,
    input  logic               rst_n,
    io_controller_if.slave     io,
    input  logic [NUM_IRQ-1:0] irq,
    output wire  [15:0]        a_bus,
    inout  wire  [15:0]        d_bus,
    output logic               dev_rd,
    output logic               dev_wr,
    output logic [3:0]         dev_addr,
    output logic [15:0]        dev_wdata,
    input  logic [15:0]        dev_rdata
);

    localparam logic [3:0] AddrPending = 4'd0;
    localparam logic [3:0] AddrEnable  = 4'd1;
    localparam logic [3:0] AddrLastId  = 4'd2;

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic               in_service_q, in_service_d;
    logic [15:0]        retaddr_q, retaddr_d;
    logic [15:0]        rd_hold_q, rd_hold_d;
    logic [3:0]         last_id_q, last_id_d;
    logic               int_q, int_d;

    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr_mask;
    logic               any_active;
    logic [3:0]         sel;
    logic               rd_en;
    logic               wr_en;
    logic               ext_sel;
    logic [15:0]        pending_ext;
    logic [15:0]        enable_ext;
    logic [15:0]        active_ext;
    logic [15:0]        reg_rdata;
    logic               d_en;
    logic [15:0]        d_drv;

    assign rd_en   = io.io_read & io.io_addr_read;
    assign wr_en   = io.io_write & io.io_addr_read;
    assign ext_sel = (io.io_addr >= 4'd3);

    assign dev_rd    = rst_n & rd_en & ext_sel;
    assign dev_wr    = rst_n & wr_en & ext_sel;
    assign dev_addr  = io.io_addr;
    assign dev_wdata = d_bus;

    assign active     = pending_q & enable_q;
    assign any_active = |active;
    assign rise       = irq & ~irq_q;

    // Lowest index wins; falls back to 0 when nothing is active (spurious entry).
    always_comb begin
        sel = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) sel = 4'(i);
        end
    end

    always_comb begin
        pending_ext = '0;
        enable_ext  = '0;
        active_ext  = '0;
        pending_ext[NUM_IRQ-1:0] = pending_q;
        enable_ext[NUM_IRQ-1:0]  = enable_q;
        active_ext[NUM_IRQ-1:0]  = active;
    end

    always_comb begin
        case (io.io_addr)
            AddrPending: reg_rdata = pending_ext;
            AddrEnable:  reg_rdata = enable_ext;
            AddrLastId:  reg_rdata = {12'd0, last_id_q};
            default:     reg_rdata = dev_rdata;
        endcase
    end

    // Clear sources: write-1-to-clear on PENDING and the acknowledge of the selected bit.
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_mask[i] = (io.io_store_retaddr && any_active && (sel == 4'(i)))
                          || (wr_en && (io.io_addr == AddrPending) && d_bus[i]);
        end
    end

    always_comb begin
        // A new edge is OR-ed in after the clear so it is never lost.
        pending_d    = (pending_q & ~clr_mask) | rise;
        enable_d     = enable_q;
        rd_hold_d    = rd_hold_q;
        retaddr_d    = retaddr_q;
        last_id_d    = last_id_q;
        in_service_d = in_service_q;
        int_d        = any_active & ~in_service_q;

        if (wr_en && (io.io_addr == AddrEnable)) enable_d = d_bus[NUM_IRQ-1:0];
        if (rd_en) rd_hold_d = reg_rdata;

        if (io.io_store_retaddr) begin
            retaddr_d    = d_bus;
            last_id_d    = sel;
            in_service_d = 1'b1;
        end else if (io.io_push_retaddr) begin
            in_service_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q        <= '0;
            pending_q    <= '0;
            enable_q     <= '0;
            in_service_q <= 1'b0;
            retaddr_q    <= '0;
            rd_hold_q    <= '0;
            last_id_q    <= '0;
            int_q        <= 1'b0;
        end else begin
            irq_q        <= irq;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            in_service_q <= in_service_d;
            retaddr_q    <= retaddr_d;
            rd_hold_q    <= rd_hold_d;
            last_id_q    <= last_id_d;
            int_q        <= int_d;
        end
    end

    assign io.io_interrupt = int_q;

    // Drivers are gated by reset so the buses release the moment reset asserts.
    always_comb begin
        d_en  = 1'b0;
        d_drv = 16'd0;
        if (rst_n) begin
            if (io.io_push_retaddr) begin
                d_en  = 1'b1;
                d_drv = retaddr_q;
            end else if (io.io_push) begin
                d_en  = 1'b1;
                d_drv = rd_hold_q;
            end else if (io.io_push_ints) begin
                d_en  = 1'b1;
                d_drv = active_ext;
            end
        end
    end

    assign d_bus = d_en ? d_drv : 16'bz;
    assign a_bus = (rst_n && io.io_push_int_addr) ? (VECTOR_BASE + {12'd0, sel}) : 16'bz;

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller; buses carry pull-ups so a released bus reads 16'hFFFF.
module tb_io_controller;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq;
    logic [15:0] dev_rdata;
    logic        dev_rd;
    logic        dev_wr;
    logic [3:0]  dev_addr;
    logic [15:0] dev_wdata;
    wire  [15:0] a_bus;
    wire  [15:0] d_bus;
    logic        tb_den;
    logic [15:0] tb_dval;
    logic [15:0] rv;
    int          n_pass;
    int          n_total;

    io_controller_if bus ();

    pullup pu_d (d_bus);
    pullup pu_a (a_bus);
    assign d_bus = tb_den ? tb_dval : 16'bz;

    io_controller #(
        .NUM_IRQ     (8),
        .VECTOR_BASE (16'hFF00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io        (bus.slave),
        .irq       (irq),
        .a_bus     (a_bus),
        .d_bus     (d_bus),
        .dev_rd    (dev_rd),
        .dev_wr    (dev_wr),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        bus.io_addr          = 4'd0;
        bus.io_addr_read     = 1'b0;
        bus.io_read          = 1'b0;
        bus.io_push          = 1'b0;
        bus.io_write         = 1'b0;
        bus.io_store_retaddr = 1'b0;
        bus.io_push_retaddr  = 1'b0;
        bus.io_push_ints     = 1'b0;
        bus.io_push_int_addr = 1'b0;
        tb_den               = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d);
        bus.io_addr      = a;
        bus.io_addr_read = 1'b1;
        bus.io_write     = 1'b1;
        tb_den           = 1'b1;
        tb_dval          = d;
        cyc();
        clear_strobes();
    endtask

    task automatic do_read(input logic [3:0] a, output logic [15:0] v);
        bus.io_addr      = a;
        bus.io_addr_read = 1'b1;
        bus.io_read      = 1'b1;
        cyc();
        clear_strobes();
        bus.io_push = 1'b1;
        #1;
        v = d_bus;
        cyc();
        clear_strobes();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.io_addr      = 4'd5;
        bus.io_addr_read = 1'b1;
        bus.io_read      = 1'b1;
        cyc();
        n_total++;
        if (dev_rd !== 1'b0) $display("FAIL rst_dev_rd: got %b want 0", dev_rd);
        else n_pass++;
        clear_strobes();
        #1;
        n_total++;
        if (bus.io_interrupt !== 1'b0) $display("FAIL rst_int: got %b want 0", bus.io_interrupt);
        else n_pass++;
        n_total++;
        if (d_bus !== 16'hFFFF) $display("FAIL rst_dbus_z: got %h want %h", d_bus, 16'hFFFF);
        else n_pass++;
        n_total++;
        if (a_bus !== 16'hFFFF) $display("FAIL rst_abus_z: got %h want %h", a_bus, 16'hFFFF);
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();
        do_read(4'd0, rv);
        n_total++;
        if (rv !== 16'h0000) $display("FAIL rst_pending: got %h want 0000", rv);
        else n_pass++;
        do_read(4'd1, rv);
        n_total++;
        if (rv !== 16'h0000) $display("FAIL rst_enable: got %h want 0000", rv);
        else n_pass++;
        do_read(4'd2, rv);
        n_total++;
        if (rv !== 16'h0000) $display("FAIL rst_last_id: got %h want 0000", rv);
        else n_pass++;
    endtask

    task automatic test_enable_rw();
        do_write(4'd1, 16'h0005);
        bus.io_addr      = 4'd1;
        bus.io_addr_read = 1'b1;
        bus.io_read      = 1'b1;
        #1;
        n_total++;
        if (d_bus !== 16'hFFFF) $display("FAIL en_z_before: got %h want FFFF", d_bus);
        else n_pass++;
        cyc();
        clear_strobes();
        bus.io_push = 1'b1;
        #1;
        n_total++;
        if (d_bus !== 16'h0005) $display("FAIL en_push: got %h want 0005", d_bus);
        else n_pass++;
        cyc();
        clear_strobes();
        #1;
        n_total++;
        if (d_bus !== 16'hFFFF) $display("FAIL en_z_after: got %h want FFFF", d_bus);
        else n_pass++;
        do_write(4'd1, 16'hFFFF);
        do_read(4'd1, rv);
        n_total++;
        if (rv !== 16'h00FF) $display("FAIL en_upper_zero: got %h want 00FF", rv);
        else n_pass++;
    endtask

    task automatic test_irq_entry();
        do_write(4'd1, 16'h0004);
        irq = 8'h04;
        cyc();
        n_total++;
        if (bus.io_interrupt !== 1'b0) $display("FAIL irq_lat0: got %b want 0", bus.io_interrupt);
        else n_pass++;
        bus.io_push_ints = 1'b1;
        #1;
        n_total++;
        if (d_bus !== 16'h0004) $display("FAIL irq_pend_ints: got %h want 0004", d_bus);
        else n_pass++;
        bus.io_push_ints = 1'b0;
        cyc();
        n_total++;
        if (bus.io_interrupt !== 1'b1) $display("FAIL irq_raise: got %b want 1", bus.io_interrupt);
        else n_pass++;
        bus.io_store_retaddr = 1'b1;
        bus.io_push_int_addr = 1'b1;
        tb_den  = 1'b1;
        tb_dval = 16'h1234;
        #1;
        n_total++;
        if (a_bus !== 16'hFF02) $display("FAIL irq_vector: got %h want FF02", a_bus);
        else n_pass++;
        cyc();
        clear_strobes();
        #1;
        n_total++;
        if (a_bus !== 16'hFFFF) $display("FAIL irq_abus_rel: got %h want FFFF", a_bus);
        else n_pass++;
        cyc();
        n_total++;
        if (bus.io_interrupt !== 1'b0) $display("FAIL irq_drop: got %b want 0", bus.io_interrupt);
        else n_pass++;
        do_read(4'd2, rv);
        n_total++;
        if (rv !== 16'h0002) $display("FAIL irq_last_id: got %h want 0002", rv);
        else n_pass++;
        do_read(4'd0, rv);
        n_total++;
        if (rv !== 16'h0000) $display("FAIL irq_pend_clr: got %h want 0000", rv);
        else n_pass++;
        bus.io_push_retaddr = 1'b1;
        #1;
        n_total++;
        if (d_bus !== 16'h1234) $display("FAIL irq_retaddr: got %h want 1234", d_bus);
        else n_pass++;
        cyc();
        clear_strobes();
    endtask

    task automatic test_priority();
        irq = 8'h00;
        cyc();
        do_write(4'd1, 16'h00FF);
        irq = 8'h0A;
        cyc();
        cyc();
        n_total++;
        if (bus.io_interrupt !== 1'b1) $display("FAIL pri_raise: got %b want 1", bus.io_interrupt);
        else n_pass++;
        bus.io_store_retaddr = 1'b1;
        bus.io_push_int_addr = 1'b1;
        tb_den  = 1'b1;
        tb_dval = 16'h1234;
        #1;
        n_total++;
        if (a_bus !== 16'hFF01) $display("FAIL pri_vec1: got %h want FF01", a_bus);
        else n_pass++;
        cyc();
        clear_strobes();
        cyc();
        n_total++;
        if (bus.io_interrupt !== 1'b0) $display("FAIL pri_insvc: got %b want 0", bus.io_interrupt);
        else n_pass++;
        bus.io_push_retaddr = 1'b1;
        #1;
        n_total++;
        if (d_bus !== 16'h1234) $display("FAIL pri_ret1: got %h want 1234", d_bus);
        else n_pass++;
        cyc();
        clear_strobes();
        cyc();
        n_total++;
        if (bus.io_interrupt !== 1'b1) $display("FAIL pri_reassert: got %b want 1", bus.io_interrupt);
        else n_pass++;
        bus.io_store_retaddr = 1'b1;
        bus.io_push_int_addr = 1'b1;
        tb_den  = 1'b1;
        tb_dval = 16'h5678;
        #1;
        n_total++;
        if (a_bus !== 16'hFF03) $display("FAIL pri_vec3: got %h want FF03", a_bus);
        else n_pass++;
        cyc();
        clear_strobes();
        bus.io_push_retaddr = 1'b1;
        #1;
        n_total++;
        if (d_bus !== 16'h5678) $display("FAIL pri_ret2: got %h want 5678", d_bus);
        else n_pass++;
        cyc();
        clear_strobes();
        do_read(4'd2, rv);
        n_total++;
        if (rv !== 16'h0003) $display("FAIL pri_last_id: got %h want 0003", rv);
        else n_pass++;
        n_total++;
        if (bus.io_interrupt !== 1'b0) $display("FAIL pri_idle: got %b want 0", bus.io_interrupt);
        else n_pass++;
    endtask

    task automatic test_held_level();
        irq = 8'h00;
        cyc();
        irq = 8'h01;
        cyc();
        cyc();
        cyc();
        bus.io_push_ints = 1'b1;
        #1;
        n_total++;
        if (d_bus !== 16'h0001) $display("FAIL lvl_once: got %h want 0001", d_bus);
        else n_pass++;
        bus.io_push_ints = 1'b0;
        do_write(4'd0, 16'h0001);
        bus.io_push_ints = 1'b1;
        #1;
        n_total++;
        if (d_bus !== 16'h0000) $display("FAIL lvl_w1c: got %h want 0000", d_bus);
        else n_pass++;
        bus.io_push_ints = 1'b0;
        irq = 8'h00;
        cyc();
        irq = 8'h01;
        cyc();
        irq = 8'h00;
        cyc();
        // Entry acknowledges bit 0 while a fresh 0->1 edge arrives on it.
        irq = 8'h01;
        bus.io_store_retaddr = 1'b1;
        bus.io_push_int_addr = 1'b1;
        tb_den  = 1'b1;
        tb_dval = 16'h2222;
        #1;
        n_total++;
        if (a_bus !== 16'hFF00) $display("FAIL lvl_vec0: got %h want FF00", a_bus);
        else n_pass++;
        cyc();
        clear_strobes();
        bus.io_push_ints = 1'b1;
        #1;
        n_total++;
        if (d_bus !== 16'h0001) $display("FAIL lvl_edge_wins: got %h want 0001", d_bus);
        else n_pass++;
        clear_strobes();
        bus.io_push_retaddr = 1'b1;
        cyc();
        clear_strobes();
        do_write(4'd0, 16'h0001);
        irq = 8'h00;
        cyc();
    endtask

    task automatic test_external();
        bus.io_addr      = 4'd7;
        bus.io_addr_read = 1'b1;
        bus.io_write     = 1'b1;
        tb_den           = 1'b1;
        tb_dval          = 16'hBEEF;
        #1;
        n_total++;
        if (dev_wr !== 1'b1) $display("FAIL ext_wr: got %b want 1", dev_wr);
        else n_pass++;
        n_total++;
        if (dev_addr !== 4'd7) $display("FAIL ext_addr: got %h want 7", dev_addr);
        else n_pass++;
        n_total++;
        if (dev_wdata !== 16'hBEEF) $display("FAIL ext_wdata: got %h want BEEF", dev_wdata);
        else n_pass++;
        n_total++;
        if (dev_rd !== 1'b0) $display("FAIL ext_rd_idle: got %b want 0", dev_rd);
        else n_pass++;
        cyc();
        clear_strobes();
        bus.io_addr      = 4'd9;
        bus.io_addr_read = 1'b1;
        bus.io_read      = 1'b1;
        dev_rdata        = 16'h00A5;
        #1;
        n_total++;
        if (dev_rd !== 1'b1) $display("FAIL ext_rd: got %b want 1", dev_rd);
        else n_pass++;
        cyc();
        clear_strobes();
        dev_rdata   = 16'hFFFF;
        bus.io_push = 1'b1;
        #1;
        n_total++;
        if (d_bus !== 16'h00A5) $display("FAIL ext_rdata: got %h want 00A5", d_bus);
        else n_pass++;
        cyc();
        clear_strobes();
        dev_rdata = 16'h0000;
        do_write(4'd2, 16'h000F);
        do_read(4'd2, rv);
        n_total++;
        if (rv !== 16'h0000) $display("FAIL ext_lastid_ro: got %h want 0000", rv);
        else n_pass++;
    endtask

    task automatic test_reset_mid_push();
        do_write(4'd1, 16'h0005);
        irq = 8'h01;
        cyc();
        irq = 8'h00;
        cyc();
        bus.io_addr      = 4'd1;
        bus.io_addr_read = 1'b1;
        bus.io_read      = 1'b1;
        cyc();
        clear_strobes();
        bus.io_push = 1'b1;
        #1;
        n_total++;
        if (d_bus !== 16'h0005) $display("FAIL mid_push: got %h want 0005", d_bus);
        else n_pass++;
        n_total++;
        if (bus.io_interrupt !== 1'b1) $display("FAIL mid_int_pre: got %b want 1", bus.io_interrupt);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (d_bus !== 16'hFFFF) $display("FAIL mid_dbus_z: got %h want FFFF", d_bus);
        else n_pass++;
        n_total++;
        if (bus.io_interrupt !== 1'b0) $display("FAIL mid_int: got %b want 0", bus.io_interrupt);
        else n_pass++;
        clear_strobes();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();
        do_read(4'd1, rv);
        n_total++;
        if (rv !== 16'h0000) $display("FAIL mid_enable: got %h want 0000", rv);
        else n_pass++;
        do_read(4'd0, rv);
        n_total++;
        if (rv !== 16'h0000) $display("FAIL mid_pending: got %h want 0000", rv);
        else n_pass++;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        irq       = 8'h00;
        dev_rdata = 16'h0000;
        tb_dval   = 16'h0000;
        rv        = 16'h0000;
        clear_strobes();
        test_reset();
        test_enable_rw();
        test_irq_entry();
        test_priority();
        test_held_level();
        test_external();
        test_reset_mid_push();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
